uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_sched_pkg.sv | 13 +
 rtl/uart_rr_arbiter.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 120 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared state encoding and constants for the UART TX scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned FRAME_COUNT_W          = 16;
  localparam int unsigned DEFAULT_NUM_REQUESTERS = 4;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant that is
// asking wins.
module uart_rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NumRequesters = DEFAULT_NUM_REQUESTERS
) (
  input  logic [NumRequesters-1:0]         req,
  input  logic [$clog2(NumRequesters)-1:0] last_grant,
  output logic [$clog2(NumRequesters)-1:0] winner,
  output logic                             any_req
);

  localparam int unsigned GrantW = $clog2(NumRequesters);

  int unsigned idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned off = 1; off <= NumRequesters; off++) begin
      idx = (32'(last_grant) + off) % NumRequesters;
      if (!any_req && req[GrantW'(idx)]) begin
        winner  = GrantW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler multiplexing byte-stream frames onto one UART TX FIFO.
// Optional idle-beat timeout/abort is built when UART_TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NumRequesters = DEFAULT_NUM_REQUESTERS,
  parameter int unsigned NumDataBits   = 8,
  parameter int unsigned FlowControl   = 0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NumRequesters-1:0]         req_valid,
  input  logic [NumRequesters*NumDataBits-1:0] req_data,
  input  logic [NumRequesters-1:0]         req_last,
  output logic [NumRequesters-1:0]         req_ready,
  output logic [NumDataBits-1:0]           tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  input  logic                             cts_n,
  output logic [$clog2(NumRequesters)-1:0] grant,
  output logic                             busy,
  output logic                             abort,
  output logic [FRAME_COUNT_W-1:0]         frame_count
);

  localparam int unsigned GrantW = $clog2(NumRequesters);

  state_e            state;
  logic [GrantW-1:0] last_grant;
  logic [GrantW-1:0] winner;
  logic              any_req;
  logic              cts_ok;
  logic              beat;
  logic              timeout;

  uart_rr_arbiter #(
    .NumRequesters(NumRequesters)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .winner    (winner),
    .any_req   (any_req)
  );

  assign cts_ok  = (FlowControl == 0) || !cts_n;
  assign tx_data = req_data[NumDataBits*32'(grant) +: NumDataBits];
  assign beat    = tx_valid && tx_ready;

  // Zero-latency handshake path to the owner; silent outside XFER and in reset.
  always_comb begin
    tx_valid  = 1'b0;
    req_ready = '0;
    if (!reset && state == XFER) begin
      tx_valid         = req_valid[grant] && cts_ok;
      req_ready[grant] = tx_ready && cts_ok;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [CntW-1:0] idle_cnt;

  // Fires on the stalled cycle that would bring the count to TimeoutCycles-1.
  assign timeout = (state == XFER) && !beat && cts_ok &&
                   (idle_cnt == CntW'(TimeoutCycles - 2));

  always_ff @(posedge clock) begin
    if (reset || state != XFER || beat) begin
      idle_cnt <= '0;
    end else if (cts_ok) begin
      idle_cnt <= idle_cnt + CntW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TimeoutCycles);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GrantW'(NumRequesters - 1);
      grant       <= '0;
      busy        <= 1'b0;
      abort       <= 1'b0;
      frame_count <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= XFER;
            grant      <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
          end
        end
        XFER: begin
          if ((beat && req_last[grant]) || timeout) begin
            state <= GAP;
            busy  <= 1'b0;
            abort <= timeout;
            if (!timeout) frame_count <= frame_count + FRAME_COUNT_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus random
// traffic, all compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 4;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            cts_n;
  logic [1:0]      grant;
  logic            busy;
  logic            abort;
  logic [15:0]     frame_count;

  uart_tx_scheduler #(
    .NumRequesters(N), .NumDataBits(DW), .FlowControl(1), .TimeoutCycles(TO)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .cts_n(cts_n), .grant(grant),
    .busy(busy), .abort(abort), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Requester sources: queued {last, data} beats, optionally held off.
  logic [DW:0] srcq [N][$];
  logic [N-1:0] hold;

  // Reference model: phase 0 idle, 1 transferring, 2 gap.
  int ph, own, lastg, cnt, frames;
  bit ab;

  logic [DW-1:0] cap_data [$];
  int            cap_grant [$];
  int            cap_cyc [$];
  int            aborts, abort_cyc, act;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [DW:0] e;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        e = srcq[i][0];
        req_valid[i]          = !hold[i];
        req_last[i]           = e[DW];
        req_data[i*DW +: DW]  = e[DW-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic push_frame(input int r, input int len, input logic [DW-1:0] base);
    for (int k = 0; k < len; k++) srcq[r].push_back({(k == len - 1), base + DW'(k)});
  endtask

  task automatic cycle();
    logic cts_ok, e_txv, found;
    logic [N-1:0] e_rdy;
    int idx;
    drive();
    #1;
    cts_ok = !cts_n;
    e_txv  = !reset && ph == 1 && req_valid[own] && cts_ok;
    e_rdy  = '0;
    if (!reset && ph == 1 && tx_ready && cts_ok) e_rdy[own] = 1'b1;
    chk("busy", 32'(busy), 32'(ph == 1));
    chk("grant", 32'(grant), 32'(own));
    chk("abort", 32'(abort), 32'(ab));
    chk("frame_count", 32'(frame_count), 32'(frames));
    chk("tx_valid", 32'(tx_valid), 32'(e_txv));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    if (e_txv) chk("tx_data", 32'(tx_data), 32'(req_data[own*DW +: DW]));
    if (tx_valid === 1'b1 && tx_ready) begin
      cap_data.push_back(tx_data);
      cap_grant.push_back(32'(grant));
      cap_cyc.push_back(cyc);
    end
    if (abort === 1'b1) begin
      aborts++;
      abort_cyc = cyc;
    end
    if (tx_valid === 1'b1 || req_ready != 0) act++;
    @(posedge clock);
    if (reset) begin
      ph = 0; own = 0; lastg = N - 1; cnt = 0; ab = 0; frames = 0;
    end else begin
      ab = 0;
      case (ph)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            idx = (lastg + k) % N;
            if (!found && req_valid[idx]) begin
              found = 1'b1; own = idx; lastg = idx; ph = 1; cnt = 0;
            end
          end
        end
        1: begin
          if (e_txv && tx_ready) begin
            cnt = 0;
            void'(srcq[own].pop_front());
            if (req_last[own]) begin
              ph = 2; frames = (frames + 1) % 65536;
            end
          end else if (cts_ok) begin
            if (TE && cnt == TO - 2) begin
              ph = 2; ab = 1;
            end else cnt++;
          end
        end
        default: ph = 0;
      endcase
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic clear_capture();
    cap_data.delete(); cap_grant.delete(); cap_cyc.delete();
    aborts = 0; abort_cyc = -1; act = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    hold = '0; tx_ready = 1'b1; cts_n = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    clear_capture();
  endtask

  logic [DW-1:0] exp34 [6];
  int            exp35 [5];
  int            n;

  initial begin
    reset = 1'b1; tx_ready = 1'b1; cts_n = 1'b0; hold = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(posedge clock);
    ph = 0; own = 0; lastg = N - 1; cnt = 0; ab = 0; frames = 0;
    @(negedge clock);

    // Reset holds everything quiet even with requests pending.
    push_frame(2, 2, 8'h55);
    cycle();
    do_reset();

    // Two contending 3-byte frames: requester 0 first, then 2.
    exp34[0] = 8'hA1; exp34[1] = 8'hA2; exp34[2] = 8'hA3;
    exp34[3] = 8'hC1; exp34[4] = 8'hC2; exp34[5] = 8'hC3;
    push_frame(0, 3, 8'hA1);
    push_frame(2, 3, 8'hC1);
    repeat (14) cycle();
    chk("s34_count", 32'(cap_data.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk("s34_byte", (k < cap_data.size()) ? 32'(cap_data[k]) : 32'hDEAD, 32'(exp34[k]));
    chk("s34_frames", 32'(frame_count), 32'd2);

    // Everyone always asking with single-beat frames: strict rotation.
    do_reset();
    exp35[0] = 0; exp35[1] = 1; exp35[2] = 2; exp35[3] = 3; exp35[4] = 0;
    for (int i = 0; i < N; i++) begin
      push_frame(i, 1, DW'(8'h30 + i));
      push_frame(i, 1, DW'(8'h40 + i));
    end
    repeat (18) cycle();
    chk("s35_count_ge5", 32'(cap_grant.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      chk("s35_grant", (k < cap_grant.size()) ? 32'(cap_grant[k]) : 32'hDEAD, 32'(exp35[k]));
    for (int k = 0; k < 4; k++)
      chk("s35_spacing", (k + 1 < cap_cyc.size()) ? 32'(cap_cyc[k+1] - cap_cyc[k]) : 32'hDEAD, 32'd3);

    // FIFO back-pressure mid-frame: nothing lost or reordered.
    do_reset();
    push_frame(2, 3, 8'h71);
    cycle(); cycle();
    tx_ready = 1'b0;
    repeat (5) cycle();
    tx_ready = 1'b1;
    repeat (12) cycle();
    chk("s36_count", 32'(cap_data.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("s36_byte", (k < cap_data.size()) ? 32'(cap_data[k]) : 32'hDEAD, 32'(8'h71 + k));

    // Clear-to-send withheld for 10 cycles blocks the handshake, no abort.
    do_reset();
    push_frame(0, 3, 8'h91);
    cycle(); cycle();
    cts_n = 1'b1; act = 0; aborts = 0;
    repeat (10) cycle();
    chk("s37_blocked", 32'(act), 32'd0);
    chk("s37_no_abort", 32'(aborts), 32'd0);
    n = cap_data.size();
    cts_n = 1'b0;
    cycle();
    chk("s37_resume", 32'(cap_data.size()), 32'(n + 1));
    repeat (4) cycle();

    // Owner vanishes mid-frame: timeout abort (when built) hands over to 2.
    do_reset();
    push_frame(1, 2, 8'h11);
    push_frame(2, 1, 8'h21);
    cycle(); cycle();
    srcq[1].delete();
    repeat (12) cycle();
    chk("s38_aborts", 32'(aborts), TE ? 32'd1 : 32'd0);
    chk("s38_abort_cyc", 32'(abort_cyc),
        TE ? 32'((cap_cyc.size() > 0 ? cap_cyc[0] : -100) + 4) : 32'hFFFF_FFFF);
    chk("s38_frames", 32'(frame_count), TE ? 32'd1 : 32'd0);
    chk("s38_grant", 32'(grant), TE ? 32'd2 : 32'd1);

    // Reset during the second beat discards the frame; requester 0 wins next.
    do_reset();
    push_frame(3, 3, 8'hE1);
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    srcq[3].delete();
    clear_capture();
    chk("s39_busy", 32'(busy), 32'd0);
    chk("s39_count", 32'(frame_count), 32'd0);
    push_frame(0, 1, 8'h01);
    push_frame(3, 1, 8'h03);
    repeat (4) cycle();
    chk("s39_first_grant", (cap_grant.size() > 0) ? 32'(cap_grant[0]) : 32'hDEAD, 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, N - 1);
        if (srcq[n].size() < 8) push_frame(n, $urandom_range(1, 4), DW'($urandom));
      end
      tx_ready = ($urandom_range(0, 4) != 0);
      cts_n    = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
